implication_checker: RTL

Synthesizable concurrent-property checker that sits directly downstream of a stimulus/DUT stage and consumes its per-cycle signals. It evaluates `ante |-> ##DELAY <consequent on sig>`, where the consequent is one of four edge predicates, and keeps its own cycle counter. It reports each failure as a pulse, keeps a saturating failure count, captures the first failing cycle, and raises `done` after a fixed cycle budget. It is the hardware equivalent of an `assert property (... |=> (not $rose(x)))` checker, usable where simulator assertion support is absent.

---
 rtl/implication_checker.sv | 94 +++++++++
 1 files changed

// File: rtl/implication_checker.sv
// Hardware checker for "ante |-> ##DELAY <edge predicate on sig>" with a cycle budget,
// saturating failure count and first-failure capture.
module implication_checker #(
  parameter int unsigned DELAY     = 1,
  parameter int unsigned CYC_LIMIT = 11,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ante,
  input  logic             sig,
  input  logic [1:0]       mode,
  output logic [31:0]      cyc,
  output logic             fail,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [31:0]      first_fail_cyc,
  output logic             done
);

  localparam logic [1:0] ModeNotRose = 2'b00;
  localparam logic [1:0] ModeRose    = 2'b01;
  localparam logic [1:0] ModeNotFell = 2'b10;
  localparam logic [1:0] ModeFell    = 2'b11;

  logic             sig_q;
  logic [DELAY-1:0] pend_q, pend_d;
  logic             active;
  logic             rose, fell;
  logic             conseq_ok;
  logic             eval_fail;
  logic [31:0]      cyc_inc;

  assign active  = en & ~done;
  assign rose    = sig & ~sig_q;
  assign fell    = ~sig & sig_q;
  assign cyc_inc = cyc + 32'd1;

  always_comb begin
    conseq_ok = 1'b1;
    unique case (mode)
      ModeNotRose: conseq_ok = ~rose;
      ModeRose:    conseq_ok = rose;
      ModeNotFell: conseq_ok = ~fell;
      ModeFell:    conseq_ok = fell;
      default:     conseq_ok = 1'b1;
    endcase
  end

  // The obligation leaving the top of the pipeline is the one evaluated on this edge.
  assign eval_fail = active & pend_q[DELAY-1] & ~conseq_ok;

  always_comb begin
    pend_d    = '0;
    pend_d[0] = ante;
    for (int i = 1; i < int'(DELAY); i++) begin
      pend_d[i] = pend_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q            <= 1'b0;
      pend_q           <= '0;
      cyc              <= 32'd0;
      fail             <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_cyc   <= 32'd0;
      done             <= 1'b0;
    end else begin
      fail <= eval_fail;
      if (active) begin
        sig_q  <= sig;
        pend_q <= pend_d;
        cyc    <= cyc_inc;
        if (cyc_inc == CYC_LIMIT) begin
          done <= 1'b1;
        end
        if (eval_fail) begin
          if (fail_count != '1) begin
            fail_count <= fail_count + 1'b1;
          end
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_cyc   <= cyc;
          end
        end
      end
    end
  end

endmodule
